// File: rtl/find_extreme_n.sv
// Streaming max/min search over a valid-qualified sample stream, with sample counting and saturation flag.
// Optional macro FIND_EXTREME_IDX_EN builds the result index register; otherwise result_idx is tied to 0.
module find_extreme_n #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SIGNED_CMP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              last,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  result_idx,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              finish,
    output logic              sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mode_q;
    logic   accept;
    logic   take;
    logic   greater;
    logic   less;

    // Strict comparison against the running extreme; signedness fixed at elaboration.
    always_comb begin
        greater = 1'b0;
        less    = 1'b0;
        if (SIGNED_CMP != 0) begin
            greater = $signed(data) > $signed(result);
            less    = $signed(data) < $signed(result);
        end else begin
            greater = data > result;
            less    = data < result;
        end
    end

    // Next state; start restarts from any state, so it takes priority over last.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        take    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (start) begin
                    state_d = RUN;
                end else if (valid) begin
                    accept = 1'b1;
                    if (last) state_d = DONE;
                end
            end
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        take = accept && ((count == '0) || (mode_q ? less : greater));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            result  <= '0;
            count   <= '0;
            busy    <= 1'b0;
            finish  <= 1'b0;
            sat     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN);
            finish  <= (state_d == DONE);
            if (start) begin
                mode_q <= mode;
                result <= '0;
                count  <= '0;
                sat    <= 1'b0;
            end else if (accept) begin
                if (take) result <= data;
                if (count != CNT_MAX) count <= count + CNT_W'(1);
                // Sticky once the counter reaches its ceiling.
                if (count >= CNT_MAX - CNT_W'(1)) sat <= 1'b1;
            end
        end
    end

`ifdef FIND_EXTREME_IDX_EN
    // Index follows the pre-increment count, which itself clamps at CNT_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_idx <= '0;
        end else if (start && (state_q != DONE || start)) begin
            result_idx <= '0;
        end else if (take) begin
            result_idx <= count;
        end
    end
`else
    assign result_idx = '0;
`endif

endmodule

// File: tb/tb_find_extreme_n.sv
// Directed bench for find_extreme_n: per-cycle vector table on the default build plus
// hand sequences for signed compare and counter saturation on extra instances.
module tb_find_extreme_n;

    logic       clk = 1'b0;
    logic       rst, start, mode, valid, last;
    logic [7:0] data;

    logic [7:0] r0, i0, c0;
    logic       b0, f0, s0;
    logic [7:0] r1, i1, c1;
    logic       b1, f1, s1;
    logic [7:0] r2;
    logic [2:0] i2, c2;
    logic       b2, f2, s2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    find_extreme_n u0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .valid(valid), .data(data), .last(last),
        .result(r0), .result_idx(i0), .count(c0), .busy(b0), .finish(f0), .sat(s0));

    find_extreme_n #(.SIGNED_CMP(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .valid(valid), .data(data), .last(last),
        .result(r1), .result_idx(i1), .count(c1), .busy(b1), .finish(f1), .sat(s1));

    find_extreme_n #(.CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .valid(valid), .data(data), .last(last),
        .result(r2), .result_idx(i2), .count(c2), .busy(b2), .finish(f2), .sat(s2));

    typedef struct {
        logic       rst, start, mode, valid;
        logic [7:0] data;
        logic       last;
        logic [7:0] res, idx, cnt;
        logic       busy, fin, sat;
    } vec_t;

    localparam int NV = 30;
    vec_t tv[NV];

    function automatic vec_t mk(input logic r, input logic st, input logic m, input logic v,
                                input logic [7:0] d, input logic l, input logic [7:0] res,
                                input logic [7:0] idx, input logic [7:0] cnt, input logic b,
                                input logic f, input logic s);
        vec_t x;
        x.rst = r; x.start = st; x.mode = m; x.valid = v; x.data = d; x.last = l;
        x.res = res; x.idx = idx; x.cnt = cnt; x.busy = b; x.fin = f; x.sat = s;
        return x;
    endfunction

    // Expected index depends on whether the index register is built.
    function automatic logic [7:0] xi(input logic [7:0] v);
`ifdef FIND_EXTREME_IDX_EN
        return v;
`else
        return 8'(v & 8'h00);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic m, input logic v,
                        input logic [7:0] d, input logic l);
        @(negedge clk);
        rst = r; start = st; mode = m; valid = v; data = d; last = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; valid = 1'b0; data = '0; last = 1'b0;

        //              rst st m  v  data  l   res idx cnt b  f  s
        tv[0]  = mk(1, 0, 0, 0, 8'd0,   0,  0,  0, 0, 0, 0, 0);
        tv[1]  = mk(0, 0, 0, 1, 8'd55,  0,  0,  0, 0, 0, 0, 0);
        tv[2]  = mk(0, 1, 0, 1, 8'd77,  0,  0,  0, 0, 1, 0, 0);
        tv[3]  = mk(0, 0, 0, 1, 8'd3,   0,  3,  0, 1, 1, 0, 0);
        tv[4]  = mk(0, 0, 0, 0, 8'd50,  1,  3,  0, 1, 1, 0, 0);
        tv[5]  = mk(0, 0, 0, 1, 8'd9,   0,  9,  1, 2, 1, 0, 0);
        tv[6]  = mk(0, 0, 0, 1, 8'd9,   0,  9,  1, 3, 1, 0, 0);
        tv[7]  = mk(0, 0, 0, 1, 8'd2,   1,  9,  1, 4, 0, 1, 0);
        tv[8]  = mk(0, 0, 0, 0, 8'd0,   0,  9,  1, 4, 0, 0, 0);
        tv[9]  = mk(0, 0, 0, 1, 8'd100, 1,  9,  1, 4, 0, 0, 0);
        tv[10] = mk(0, 1, 0, 0, 8'd0,   0,  0,  0, 0, 1, 0, 0);
        tv[11] = mk(0, 0, 0, 1, 8'd50,  0, 50,  0, 1, 1, 0, 0);
        tv[12] = mk(0, 0, 0, 1, 8'd60,  0, 60,  1, 2, 1, 0, 0);
        tv[13] = mk(0, 1, 0, 1, 8'd99,  0,  0,  0, 0, 1, 0, 0);
        tv[14] = mk(0, 0, 0, 1, 8'd4,   0,  4,  0, 1, 1, 0, 0);
        tv[15] = mk(0, 0, 0, 1, 8'd1,   1,  4,  0, 2, 0, 1, 0);
        tv[16] = mk(0, 1, 1, 0, 8'd0,   0,  0,  0, 0, 1, 0, 0);
        tv[17] = mk(0, 0, 0, 1, 8'd20,  0, 20,  0, 1, 1, 0, 0);
        tv[18] = mk(0, 0, 0, 1, 8'd30,  0, 20,  0, 2, 1, 0, 0);
        tv[19] = mk(0, 0, 0, 1, 8'd5,   0,  5,  2, 3, 1, 0, 0);
        tv[20] = mk(0, 0, 0, 1, 8'd5,   0,  5,  2, 4, 1, 0, 0);
        tv[21] = mk(0, 0, 0, 1, 8'd200, 1,  5,  2, 5, 0, 1, 0);
        tv[22] = mk(0, 0, 0, 0, 8'd0,   0,  5,  2, 5, 0, 0, 0);
        tv[23] = mk(0, 1, 0, 0, 8'd0,   0,  0,  0, 0, 1, 0, 0);
        tv[24] = mk(0, 0, 0, 1, 8'd7,   0,  7,  0, 1, 1, 0, 0);
        tv[25] = mk(0, 0, 0, 1, 8'd8,   0,  8,  1, 2, 1, 0, 0);
        tv[26] = mk(0, 0, 0, 1, 8'd9,   0,  9,  2, 3, 1, 0, 0);
        tv[27] = mk(1, 1, 1, 1, 8'd10,  1,  0,  0, 0, 0, 0, 0);
        tv[28] = mk(0, 0, 0, 1, 8'd11,  1,  0,  0, 0, 0, 0, 0);
        tv[29] = mk(0, 0, 0, 0, 8'd0,   0,  0,  0, 0, 0, 0, 0);

        for (int k = 0; k < NV; k++) begin
            step(tv[k].rst, tv[k].start, tv[k].mode, tv[k].valid, tv[k].data, tv[k].last);
            chk($sformatf("v%0d result", k), 32'(r0), 32'(tv[k].res));
            chk($sformatf("v%0d idx", k),    32'(i0), 32'(xi(tv[k].idx)));
            chk($sformatf("v%0d count", k),  32'(c0), 32'(tv[k].cnt));
            chk($sformatf("v%0d busy", k),   32'(b0), 32'(tv[k].busy));
            chk($sformatf("v%0d finish", k), 32'(f0), 32'(tv[k].fin));
            chk($sformatf("v%0d sat", k),    32'(s0), 32'(tv[k].sat));
        end

        // Signed minimum: 0xF0 is -16 signed but 240 unsigned.
        step(0, 1, 1, 0, 8'h00, 0);
        step(0, 0, 0, 1, 8'h05, 0);
        step(0, 0, 0, 1, 8'hF0, 0);
        step(0, 0, 0, 1, 8'h7F, 1);
        chk("sgn result", 32'(r1), 32'h0F0);
        chk("sgn idx",    32'(i1), 32'(xi(8'd1)));
        chk("sgn count",  32'(c1), 32'd3);
        chk("sgn finish", 32'(f1), 32'd1);
        chk("uns result", 32'(r0), 32'h005);
        chk("uns idx",    32'(i0), 32'(xi(8'd0)));
        step(0, 0, 0, 0, 8'h00, 0);
        chk("sgn finish drop", 32'(f1), 32'd0);
        chk("sgn hold",        32'(r1), 32'h0F0);

        // Saturation on the 3-bit counter instance; the default instance keeps counting.
        step(0, 1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            d = (k == 8) ? 8'hAA : (k == 9) ? 8'h10 : 8'(k * 3);
            step(0, 0, 0, 1, d, (k == 9));
            if (k == 5) begin
                chk("sat6 count", 32'(c2), 32'd6);
                chk("sat6 sat",   32'(s2), 32'd0);
            end
        end
        chk("sat count",  32'(c2), 32'd7);
        chk("sat sat",    32'(s2), 32'd1);
        chk("sat result", 32'(r2), 32'h0AA);
        chk("sat idx",    32'(i2), 32'(xi(8'd7)));
        chk("sat finish", 32'(f2), 32'd1);
        chk("sat busy",   32'(b2), 32'd0);
        chk("wide count", 32'(c0), 32'd10);
        chk("wide idx",   32'(i0), 32'(xi(8'd8)));
        chk("wide sat",   32'(s0), 32'd0);
        step(0, 0, 0, 0, 8'h00, 0);
        chk("sat hold", 32'(s2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
